rv_mem_if: RTL and testbench
============================

Name: rv_mem_if

Overview:
Memory access unit between the multicycle RISC-V control/datapath and a variable-latency word memory. It accepts one fetch, load or store request at a time from the core and runs a req/ack handshake with memory. It returns read data plus a one-cycle completion pulse, and the control FSM holds its current state until that pulse arrives. It also rejects misaligned word accesses before they reach memory.

Parameters:
ADDR_W, 32, width of byte address on both sides
DATA_W, 32, width of data words
TIMEOUT_CYC, 16, max cycles waiting for mem_ack (used only with RV_MEM_TIMEOUT_EN); legal range 2..65535

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  request strobe from core, sampled only in IDLE
cpu_we  in  1  1 = store, 0 = read (fetch/load)
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  read data, registered
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  error flag, valid only when cpu_ready=1
cpu_busy  out  1  transaction in progress
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory acknowledge

Behaviour:
- Reset values: all outputs 0, cpu_rdata = 0, state = IDLE. Reset asserted mid-transaction drops mem_req immediately and abandons the transaction. No cpu_ready is produced for the abandoned transaction. A late mem_ack after reset is ignored.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - cpu_busy=0, mem_req=0.
  - On cpu_req=1 with cpu_addr[1:0]==0: latch addr/we/wdata into mem_* and go to ACCESS.
  - On cpu_req=1 with cpu_addr[1:0]!=0: set the error flag, do not touch memory, go to RESP.
  - mem_ack in IDLE is ignored.
- ACCESS:
  - cpu_busy=1, mem_req=1. mem_addr, mem_we and mem_wdata are held stable for the whole state.
  - At the first edge where mem_ack=1: capture mem_rdata into cpu_rdata (reads only), clear the error flag, go to RESP.
  - mem_req is 0 in the following cycle.
- RESP:
  - cpu_ready=1 for exactly one cycle, cpu_err = latched error flag, cpu_busy=1.
  - Next state is IDLE unconditionally. cpu_req in RESP is ignored; the core re-requests after seeing cpu_ready.
- Latency (cpu_req sampled at edge E0):
  - mem_req high in the cycle after E0.
  - Zero-wait memory (ack in the first ACCESS cycle): cpu_ready high in the 2nd cycle after E0.
  - Each extra wait cycle adds 1 cycle.
  - Misaligned request: cpu_ready high in the 1st cycle after E0.
- cpu_rdata:
  - Updated only by a successful read.
  - Holds its value across stores, errors and idle cycles.
  - Stores never modify it.
- cpu_req while cpu_busy=1 is ignored; no queuing.
- Address and data widths pass through unchanged. No byte enables; all accesses are word accesses.

Optional Feature:
Macro RV_MEM_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to ACCESS and increments each ACCESS cycle with mem_ack=0.
  - When the counter reaches TIMEOUT_CYC without an ack: drop mem_req, set the error flag, go to RESP (cpu_ready=1, cpu_err=1). cpu_rdata is unchanged.
  - An ack arriving in the same cycle as the timeout wins: normal completion, cpu_err=0.
- Not defined:
  - No counter logic exists and TIMEOUT_CYC is unused.
  - ACCESS waits indefinitely for mem_ack.

Test Plan:
- Reset: rst=1 mid-ACCESS → mem_req, cpu_busy and cpu_ready drop to 0 asynchronously. A mem_ack pulse after rst release is ignored and no cpu_ready appears.
- Zero-wait read: addr=0x100 and mem_rdata=0xDEADBEEF with ack in the first ACCESS cycle → mem_addr=0x100, mem_we=0. cpu_ready pulses 2 cycles after the request, cpu_rdata=0xDEADBEEF, cpu_err=0.
- 3-wait store: we=1, addr=0x204, wdata=0x12345678, ack after 3 cycles → mem_wdata stable for 4 ACCESS cycles. cpu_ready pulses 5 cycles after the request. cpu_rdata keeps its previous value of 0xDEADBEEF.
- Misaligned: addr=0x102 → mem_req never asserts. cpu_ready and cpu_err both pulse 1 cycle after the request.
- Busy: a second cpu_req while in ACCESS → ignored; exactly one mem_req transaction and one cpu_ready.
- With RV_MEM_TIMEOUT_EN and TIMEOUT_CYC=4, memory never acks → mem_req high for 4 cycles, then cpu_ready=1 and cpu_err=1, cpu_rdata unchanged. Repeat with ack on the 4th cycle → cpu_err=0.

Source files
------------

// File: rtl/rv_mem_if.sv
// rv_mem_if: single-outstanding memory access unit between the multicycle core and a req/ack word memory.
// Latency: request sampled at E0 -> mem_req next cycle; cpu_ready 2 cycles after E0 with a zero-wait ack (+1 per wait), 1 cycle for misaligned.
// Backpressure: cpu_req is only sampled in IDLE; memory stalls are absorbed in ACCESS. Optional timeout: define RV_MEM_TIMEOUT_EN.
module rv_mem_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   err_flag;
  logic   acc_tout;
  logic   req_aligned;

  // A timeout outside 2..65535 cannot be honoured by the counter; stop elaboration early.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("rv_mem_if: TIMEOUT_CYC must be within 2..65535");
  end

  assign req_aligned = (cpu_addr[1:0] == 2'b00);

`ifdef RV_MEM_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tout_cnt;

  // Count un-acked ACCESS cycles; held at zero outside ACCESS so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_cnt <= '0;
    end else if (state != ACCESS) begin
      tout_cnt <= '0;
    end else if (!mem_ack) begin
      tout_cnt <= tout_cnt + CNT_W'(1);
    end
  end

  // Give up on the cycle the count would reach TIMEOUT_CYC; a same-cycle ack takes priority.
  assign acc_tout = (state == ACCESS) && !mem_ack && (tout_cnt == CNT_LAST);
`else
  assign acc_tout = 1'b0;
`endif

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE launches or rejects, ACCESS waits for ack (or timeout), RESP lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = req_aligned ? ACCESS : RESP;
      ACCESS:  if (mem_ack || acc_tout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory-side signals, read data capture and the error flag reported in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (req_aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              err_flag  <= 1'b0;
            end else begin
              err_flag  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err_flag <= 1'b0;
            if (!mem_we) cpu_rdata <= mem_rdata;
          end else if (acc_tout) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err_flag <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_ready = (state == RESP);
  assign cpu_err   = (state == RESP) && err_flag;
  assign cpu_busy  = (state != IDLE);

endmodule

// File: tb/tb_rv_mem_if.sv
// tb_rv_mem_if: scenario tasks drive the core/memory sides; expected completions are queued at request time
// and popped by a monitor whenever cpu_ready is seen. Outputs are sampled 1 time unit after the rising edge,
// completions on the falling edge. Timeout scenarios use TIMEOUT_CYC=4 and follow RV_MEM_TIMEOUT_EN.
module tb_rv_mem_if;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   ready_cnt;

  rv_mem_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && cpu_ready) begin
      ready_cnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ready: got cpu_ready=1 rdata=%h, required no completion", cpu_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (cpu_err !== e.err) begin
          bad++;
          $display("FAIL sb_err: got %b required %b", cpu_err, e.err);
        end
        total++;
        if (cpu_rdata !== e.rdata) begin
          bad++;
          $display("FAIL sb_rdata: got %h required %h", cpu_rdata, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    tick();
    cpu_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({mem_req, mem_we, cpu_ready, cpu_err, cpu_busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, cpu_ready, cpu_err, cpu_busy});
    end
    total++;
    if ({cpu_rdata, mem_addr, mem_wdata} !== 96'b0) begin
      bad++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required all 0", cpu_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
    issue(1'b0, 32'h100, 32'h0);
    total++;
    if ({mem_req, mem_we, cpu_busy, cpu_ready} !== 4'b1010 || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL zw_access: got req/we/busy/rdy=%b addr=%h required 1010 addr=00000100",
               {mem_req, mem_we, cpu_busy, cpu_ready}, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack   = 1'b0;
    total++;
    if ({cpu_ready, cpu_err, mem_req} !== 3'b100 || cpu_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL zw_resp: got rdy/err/req=%b rdata=%h required 100 rdata=deadbeef",
               {cpu_ready, cpu_err, mem_req}, cpu_rdata);
    end
    tick();
    total++;
    if ({cpu_ready, cpu_busy} !== 2'b00) begin
      bad++;
      $display("FAIL zw_idle: got rdy/busy=%b required 00", {cpu_ready, cpu_busy});
    end
  endtask

  task automatic test_store_wait();
    q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
    mem_rdata = 32'hBAD0BAD0;
    issue(1'b1, 32'h204, 32'h12345678);
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({mem_req, mem_we, cpu_ready} !== 3'b110 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h204) begin
        bad++;
        $display("FAIL st_access_%0d: got req/we/rdy=%b addr=%h wdata=%h required 110 00000204 12345678",
                 i, {mem_req, mem_we, cpu_ready}, mem_addr, mem_wdata);
      end
      if (i == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({cpu_ready, cpu_err, mem_req} !== 3'b100 || cpu_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL st_resp: got rdy/err/req=%b rdata=%h required 100 rdata=deadbeef",
               {cpu_ready, cpu_err, mem_req}, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_misaligned();
    q.push_back('{err: 1'b1, rdata: 32'hDEADBEEF});
    issue(1'b0, 32'h102, 32'h0);
    total++;
    if ({cpu_ready, cpu_err, mem_req, cpu_busy} !== 4'b1101) begin
      bad++;
      $display("FAIL mis_resp: got rdy/err/req/busy=%b required 1101", {cpu_ready, cpu_err, mem_req, cpu_busy});
    end
    // A stray ack in IDLE must not start or finish anything.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({cpu_ready, mem_req, cpu_busy} !== 3'b000) begin
      bad++;
      $display("FAIL mis_after: got rdy/req/busy=%b required 000", {cpu_ready, mem_req, cpu_busy});
    end
    tick();
  endtask

  task automatic test_busy();
    int  rises;
    int  r0;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    r0    = ready_cnt;
    q.push_back('{err: 1'b0, rdata: 32'hCAFEF00D});
    issue(1'b0, 32'h300, 32'h0);
    // Keep requesting through ACCESS and RESP; none of it may be taken.
    cpu_req  = 1'b1;
    cpu_addr = 32'h400;
    for (int i = 1; i <= 6; i++) begin
      if (mem_req && !prev) rises++;
      prev = mem_req;
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        total++;
        if (mem_addr !== 32'h300) begin
          bad++;
          $display("FAIL busy_addr: got %h required 00000300", mem_addr);
        end
      end
      if (i == 3) begin
        mem_ack = 1'b0;
        cpu_req = 1'b1;
      end
      if (i == 4) cpu_req = 1'b0;
      tick();
    end
    total++;
    if (rises !== 1) begin
      bad++;
      $display("FAIL busy_mem_req_count: got %0d required 1", rises);
    end
    total++;
    if (ready_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL busy_ready_count: got %0d required 1", ready_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 32'h500, 32'h0);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got mem_req=%b required 1", mem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_req, cpu_busy, cpu_ready} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async: got req/busy/rdy=%b required 000", {mem_req, cpu_busy, cpu_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({cpu_ready, cpu_busy, mem_req} !== 3'b000 || cpu_rdata !== 32'h0) begin
        bad++;
        $display("FAIL rst_late_ack_%0d: got rdy/busy/req=%b rdata=%h required 000 rdata=0",
                 i, {cpu_ready, cpu_busy, mem_req}, cpu_rdata);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    // Seed cpu_rdata with a known read.
    q.push_back('{err: 1'b0, rdata: 32'h600DCAFE});
    issue(1'b0, 32'h600, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h600DCAFE;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h11111111;
    tick();
`ifdef RV_MEM_TIMEOUT_EN
    q.push_back('{err: 1'b1, rdata: 32'h600DCAFE});
    issue(1'b0, 32'h700, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({mem_req, cpu_ready} !== 2'b10) begin
        bad++;
        $display("FAIL to_wait_%0d: got req/rdy=%b required 10", i, {mem_req, cpu_ready});
      end
      tick();
    end
    total++;
    if ({cpu_ready, cpu_err, mem_req} !== 3'b110 || cpu_rdata !== 32'h600DCAFE) begin
      bad++;
      $display("FAIL to_resp: got rdy/err/req=%b rdata=%h required 110 rdata=600dcafe",
               {cpu_ready, cpu_err, mem_req}, cpu_rdata);
    end
    tick();
    q.push_back('{err: 1'b0, rdata: 32'h0A0A0A0A});
    issue(1'b0, 32'h704, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h0A0A0A0A;
      end
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({cpu_ready, cpu_err} !== 2'b10 || cpu_rdata !== 32'h0A0A0A0A) begin
      bad++;
      $display("FAIL to_ack_wins: got rdy/err=%b rdata=%h required 10 rdata=0a0a0a0a",
               {cpu_ready, cpu_err}, cpu_rdata);
    end
    tick();
`else
    // Without the timeout the access must wait as long as memory takes.
    q.push_back('{err: 1'b0, rdata: 32'h0BADF00D});
    issue(1'b0, 32'h704, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      total++;
      if ({mem_req, cpu_ready} !== 2'b10) begin
        bad++;
        $display("FAIL nto_wait_%0d: got req/rdy=%b required 10", i, {mem_req, cpu_ready});
      end
      if (i == 20) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
      end
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({cpu_ready, cpu_err} !== 2'b10 || cpu_rdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL nto_resp: got rdy/err=%b rdata=%h required 10 rdata=0badf00d",
               {cpu_ready, cpu_err}, cpu_rdata);
    end
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    ready_cnt = 0;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_store_wait();
    test_misaligned();
    test_busy();
    test_reset_mid_access();
    test_timeout();
    tick();
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending completions required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
